// File: rtl/seq_pkg.sv
// Shared definitions for the multi-cycle RV32I sequencer: state encoding
// and the load/store opcodes.
package seq_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        FETCH  = 3'd1,
        DECODE = 3'd2,
        EXEC   = 3'd3,
        MEM    = 3'd4,
        WB     = 3'd5,
        FAULT  = 3'd7
    } seq_state_t;

    localparam logic [6:0] OPC_LOAD  = 7'b0000011;
    localparam logic [6:0] OPC_STORE = 7'b0100011;

endpackage

// File: rtl/seq_wait_timer.sv
// Memory wait-state counter: saturating count of stalled request cycles,
// flags expiry when the count reaches a non-zero limit.
module seq_wait_timer #(
    parameter int unsigned TW = 8
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          clear,
    input  logic          count,
    input  logic [TW-1:0] limit,
    output logic          expired
);

    logic [TW-1:0] r_cnt;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (clear) begin
            r_cnt <= '0;
        end else if (count && (r_cnt != '1)) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    // A zero limit disables the timeout entirely.
    assign expired = (limit != '0) && (r_cnt == limit);

endmodule

// File: rtl/multicycle_seq.sv
// Multi-cycle FETCH/DECODE/EXEC/MEM/WB sequencer over a shared memory port.
// Define SEQ_PERF_CNT_EN to add the cycle_cnt/instret_cnt performance counters.
module multicycle_seq
    import seq_pkg::*;
#(
    parameter int unsigned MEM_TIMEOUT = 255,
    parameter int unsigned TW          = 8
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        run,
    input  logic        ctl_store,
    input  logic        ctl_mem2reg,
    input  logic        ctl_reg_write,
    input  logic        mem_ready,
    output logic        mem_req,
    output logic        mem_we,
    output logic        mem_addr_sel,
    output logic        ir_we,
    output logic        pc_we,
    output logic        rf_we,
    output logic        instret,
    output logic        fault,
    output logic [2:0]  state
`ifdef SEQ_PERF_CNT_EN
    ,
    output logic [31:0] cycle_cnt,
    output logic [31:0] instret_cnt
`endif
);

    seq_state_t r_state;
    seq_state_t w_next;
    logic       w_expired;
    logic       w_clear;
    logic       w_count;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:   if (run) w_next = FETCH;
            FETCH: begin
                if (mem_ready)      w_next = DECODE;
                else if (w_expired) w_next = FAULT;
            end
            DECODE: w_next = EXEC;
            EXEC:   w_next = (ctl_store || !ctl_mem2reg) ? MEM : WB;
            MEM: begin
                if (mem_ready)      w_next = ctl_store ? (run ? FETCH : IDLE) : WB;
                else if (w_expired) w_next = FAULT;
            end
            WB:     w_next = run ? FETCH : IDLE;
            FAULT:  w_next = FAULT;
            default: w_next = IDLE;
        endcase
    end

    always_comb begin
        mem_req      = 1'b0;
        mem_we       = 1'b0;
        mem_addr_sel = 1'b0;
        ir_we        = 1'b0;
        pc_we        = 1'b0;
        rf_we        = 1'b0;
        instret      = 1'b0;
        fault        = 1'b0;
        case (r_state)
            FETCH: begin
                mem_req = 1'b1;
                ir_we   = mem_ready;
            end
            MEM: begin
                mem_req      = 1'b1;
                mem_addr_sel = 1'b1;
                mem_we       = ctl_store;
                pc_we        = ctl_store & mem_ready;
                instret      = ctl_store & mem_ready;
            end
            WB: begin
                rf_we   = ctl_reg_write & ~ctl_store;
                pc_we   = 1'b1;
                instret = 1'b1;
            end
            FAULT:   fault = 1'b1;
            default: ;
        endcase
    end

    assign state = r_state;

    // Counter restarts on entry to a memory state and on every completed handshake.
    assign w_clear = ((w_next != r_state) && ((w_next == FETCH) || (w_next == MEM)))
                   | (mem_req & mem_ready);
    assign w_count = mem_req & ~mem_ready;

    seq_wait_timer #(
        .TW (TW)
    ) u_wait_timer (
        .clk     (clk),
        .rst_n   (rst_n),
        .clear   (w_clear),
        .count   (w_count),
        .limit   (TW'(MEM_TIMEOUT)),
        .expired (w_expired)
    );

`ifdef SEQ_PERF_CNT_EN
    logic [31:0] r_cycle_cnt;
    logic [31:0] r_instret_cnt;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_cycle_cnt   <= '0;
            r_instret_cnt <= '0;
        end else begin
            if ((r_state != IDLE) && (r_state != FAULT)) r_cycle_cnt <= r_cycle_cnt + 32'd1;
            if (instret) r_instret_cnt <= r_instret_cnt + 32'd1;
        end
    end

    assign cycle_cnt   = r_cycle_cnt;
    assign instret_cnt = r_instret_cnt;
`endif

endmodule

// File: tb/tb_multicycle_seq.sv
// Directed self-checking bench for multicycle_seq (MEM_TIMEOUT overridden to 4).
module tb_multicycle_seq;
    import seq_pkg::*;

    logic clk = 1'b0;
    logic rst_n, run, ctl_store, ctl_mem2reg, ctl_reg_write, mem_ready;
    logic mem_req, mem_we, mem_addr_sel, ir_we, pc_we, rf_we, instret, fault;
    logic [2:0] state;
`ifdef SEQ_PERF_CNT_EN
    logic [31:0] cycle_cnt, instret_cnt;
`endif
    logic [7:0] w_sb;

    int unsigned n_cmp = 0;
    int unsigned n_err = 0;

    always #5 clk = ~clk;

    multicycle_seq #(
        .MEM_TIMEOUT (4),
        .TW          (8)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .run           (run),
        .ctl_store     (ctl_store),
        .ctl_mem2reg   (ctl_mem2reg),
        .ctl_reg_write (ctl_reg_write),
        .mem_ready     (mem_ready),
        .mem_req       (mem_req),
        .mem_we        (mem_we),
        .mem_addr_sel  (mem_addr_sel),
        .ir_we         (ir_we),
        .pc_we         (pc_we),
        .rf_we         (rf_we),
        .instret       (instret),
        .fault         (fault),
        .state         (state)
`ifdef SEQ_PERF_CNT_EN
        ,
        .cycle_cnt     (cycle_cnt),
        .instret_cnt   (instret_cnt)
`endif
    );

    // Strobe vector order: req, we, addr_sel, ir_we, pc_we, rf_we, instret, fault.
    assign w_sb = {mem_req, mem_we, mem_addr_sel, ir_we, pc_we, rf_we, instret, fault};

    localparam logic [7:0] SB_NONE   = 8'b0000_0000;
    localparam logic [7:0] SB_FWAIT  = 8'b1000_0000;
    localparam logic [7:0] SB_FDONE  = 8'b1001_0000;
    localparam logic [7:0] SB_LDMEM  = 8'b1010_0000;
    localparam logic [7:0] SB_STWAIT = 8'b1110_0000;
    localparam logic [7:0] SB_STDONE = 8'b1110_1010;
    localparam logic [7:0] SB_WB     = 8'b0000_1110;
    localparam logic [7:0] SB_WB_NRF = 8'b0000_1010;
    localparam logic [7:0] SB_FAULT  = 8'b0000_0001;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Inputs for the cycle are already driven; let comb outputs settle, check, advance.
    task automatic expect_cyc(input string tag, input logic [2:0] st, input logic [7:0] sb);
        #1;
        check_eq({tag, "/state"}, 32'(state), 32'(st));
        check_eq({tag, "/strobes"}, 32'(w_sb), 32'(sb));
        tick();
    endtask

    task automatic set_alu();
        ctl_store = 1'b0; ctl_mem2reg = 1'b1; ctl_reg_write = 1'b1;
    endtask

    task automatic set_load();
        ctl_store = 1'b0; ctl_mem2reg = 1'b0; ctl_reg_write = 1'b1;
    endtask

    task automatic set_store();
        ctl_store = 1'b1; ctl_mem2reg = 1'b1; ctl_reg_write = 1'b1;
    endtask

    initial begin
        rst_n = 1'b0; run = 1'b1; mem_ready = 1'b1;
        set_alu();
        tick();
        tick();
        expect_cyc("reset", 3'd0, SB_NONE);

`ifdef SEQ_PERF_CNT_EN
        // Three back-to-back ADDs, run dropped during the last one.
        rst_n = 1'b1;
        expect_cyc("perf_idle", 3'd0, SB_NONE);
        for (int i = 0; i < 3; i++) begin
            expect_cyc("perf_fetch", 3'd1, SB_FDONE);
            if (i == 2) run = 1'b0;
            expect_cyc("perf_decode", 3'd2, SB_NONE);
            expect_cyc("perf_exec", 3'd3, SB_NONE);
            expect_cyc("perf_wb", 3'd5, SB_WB);
        end
        #1;
        check_eq("perf_end_state", 32'(state), 32'd0);
        check_eq("cycle_cnt", cycle_cnt, 32'd12);
        check_eq("instret_cnt", instret_cnt, 32'd3);
        rst_n = 1'b0; run = 1'b1;
        tick();
        check_eq("cycle_cnt_rst", cycle_cnt, 32'd0);
        check_eq("instret_cnt_rst", instret_cnt, 32'd0);
`endif

        // ADD, zero wait states
        rst_n = 1'b1; run = 1'b1; mem_ready = 1'b1; set_alu();
        expect_cyc("add_idle", 3'd0, SB_NONE);
        expect_cyc("add_fetch", 3'd1, SB_FDONE);
        expect_cyc("add_decode", 3'd2, SB_NONE);
        expect_cyc("add_exec", 3'd3, SB_NONE);
        expect_cyc("add_wb", 3'd5, SB_WB);

        // Load with two wait states in MEM
        expect_cyc("ld_fetch", 3'd1, SB_FDONE);
        set_load();
        expect_cyc("ld_decode", 3'd2, SB_NONE);
        expect_cyc("ld_exec", 3'd3, SB_NONE);
        mem_ready = 1'b0;
        expect_cyc("ld_mem_w1", 3'd4, SB_LDMEM);
        expect_cyc("ld_mem_w2", 3'd4, SB_LDMEM);
        mem_ready = 1'b1;
        expect_cyc("ld_mem_rdy", 3'd4, SB_LDMEM);
        expect_cyc("ld_wb", 3'd5, SB_WB);

        // Store: one wait cycle then handshake retires directly from MEM
        expect_cyc("st_fetch", 3'd1, SB_FDONE);
        set_store();
        expect_cyc("st_decode", 3'd2, SB_NONE);
        expect_cyc("st_exec", 3'd3, SB_NONE);
        mem_ready = 1'b0;
        expect_cyc("st_mem_wait", 3'd4, SB_STWAIT);
        mem_ready = 1'b1;
        expect_cyc("st_mem_rdy", 3'd4, SB_STDONE);

        // ALU op with reg_write=0: WB retires without rf_we
        expect_cyc("nrf_fetch", 3'd1, SB_FDONE);
        set_alu(); ctl_reg_write = 1'b0;
        expect_cyc("nrf_decode", 3'd2, SB_NONE);
        expect_cyc("nrf_exec", 3'd3, SB_NONE);
        expect_cyc("nrf_wb", 3'd5, SB_WB_NRF);

        // run dropped in DECODE: instruction completes, then IDLE
        set_alu();
        expect_cyc("stop_fetch", 3'd1, SB_FDONE);
        run = 1'b0;
        expect_cyc("stop_decode", 3'd2, SB_NONE);
        expect_cyc("stop_exec", 3'd3, SB_NONE);
        expect_cyc("stop_wb", 3'd5, SB_WB);
        expect_cyc("stop_idle1", 3'd0, SB_NONE);
        expect_cyc("stop_idle2", 3'd0, SB_NONE);
        run = 1'b1;
        expect_cyc("restart_idle", 3'd0, SB_NONE);
        expect_cyc("restart_fetch", 3'd1, SB_FDONE);
        set_load();
        expect_cyc("rstmem_decode", 3'd2, SB_NONE);
        expect_cyc("rstmem_exec", 3'd3, SB_NONE);
        mem_ready = 1'b0; rst_n = 1'b0;
        expect_cyc("rstmem_mem", 3'd4, SB_LDMEM);
        expect_cyc("rstmem_after", 3'd0, SB_NONE);

        // Handshake on the limit cycle wins over the timeout
        rst_n = 1'b1; set_alu();
        expect_cyc("lim_idle", 3'd0, SB_NONE);
        for (int i = 0; i < 4; i++) expect_cyc("lim_fwait", 3'd1, SB_FWAIT);
        mem_ready = 1'b1;
        expect_cyc("lim_fetch_rdy", 3'd1, SB_FDONE);
        expect_cyc("lim_decode", 3'd2, SB_NONE);

        // Timeout in FETCH: counter reaches 4 on the fifth stalled cycle
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1; mem_ready = 1'b0;
        expect_cyc("to_idle", 3'd0, SB_NONE);
        for (int i = 0; i < 5; i++) expect_cyc("to_fwait", 3'd1, SB_FWAIT);
        expect_cyc("to_fault", 3'd7, SB_FAULT);
        mem_ready = 1'b1;
        expect_cyc("to_sticky1", 3'd7, SB_FAULT);
        expect_cyc("to_sticky2", 3'd7, SB_FAULT);
        rst_n = 1'b0;
        expect_cyc("to_in_rst", 3'd7, SB_FAULT);
        expect_cyc("to_cleared", 3'd0, SB_NONE);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
